// File: rtl/score_ctrl.sv
// Score keeper for a one-button game: press/hold scoring, freeze on game over,
// high-score tracking and a glitch-free sequential BCD converter for the display.
module score_ctrl #(
    parameter int SCORE_MAX   = 255,
    parameter int HOLD_FRAMES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_move,
    input  logic       i_game_over,
    input  logic       i_restart,
    output logic [7:0] o_score,
    output logic [7:0] o_high_score,
    output logic [3:0] o_hundreds,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_bcd_valid,
    output logic       o_frozen
);

    localparam int              HW        = $clog2(HOLD_FRAMES);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [7:0]      SCORE_TOP = 8'(SCORE_MAX);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } game_state_t;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_LOAD  = 2'd1,
        CV_SHIFT = 2'd2
    } conv_state_t;

    game_state_t r_game_state;
    game_state_t w_game_next;
    conv_state_t r_conv_state;
    conv_state_t w_conv_next;

    logic [7:0]    r_score;
    logic [7:0]    r_high_score;
    logic [HW-1:0] r_hold;
    logic          r_prev_move;

    logic [7:0]    w_score_next;
    logic [7:0]    w_score_inc;
    logic [HW-1:0] w_hold_next;
    logic          w_score_chg;
    logic          w_play_tick;
    logic          w_freeze_edge;

    logic [7:0]    r_bin;
    logic [11:0]   r_bcd;
    logic [2:0]    r_cnt;
    logic [3:0]    r_hundreds;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_bcd_valid;

    logic [11:0]   w_bcd_adj;
    logic [11:0]   w_bcd_step;
    logic [7:0]    w_bin_step;

    // ---------------- game FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_game_state <= ST_RUN;
        end else begin
            r_game_state <= w_game_next;
        end
    end

    always_comb begin
        w_game_next = r_game_state;
        if (i_restart) begin
            w_game_next = ST_RUN;
        end else if (r_game_state == ST_RUN && i_game_over) begin
            w_game_next = ST_FROZEN;
        end
    end

    always_comb begin
        w_freeze_edge = (r_game_state == ST_RUN) && i_game_over && !i_restart;
        w_play_tick   = (r_game_state == ST_RUN) && i_frame_tick && !i_game_over && !i_restart;
    end

    assign o_frozen = (r_game_state == ST_FROZEN);

    // ---------------- score datapath ----------------
    assign w_score_inc = (r_score == SCORE_TOP) ? r_score : r_score + 8'd1;

    always_comb begin
        w_score_next = r_score;
        w_hold_next  = r_hold;
        if (i_restart) begin
            w_score_next = 8'd0;
            w_hold_next  = '0;
        end else if (w_play_tick) begin
            if (i_move && !r_prev_move) begin
                w_score_next = w_score_inc;
                w_hold_next  = '0;
            end else if (i_move) begin
                if (r_hold == HOLD_LAST) begin
                    w_score_next = w_score_inc;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold + HW'(1);
                end
            end else begin
                w_hold_next = '0;
            end
        end
    end

    assign w_score_chg = (w_score_next != r_score);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_score      <= 8'd0;
            r_high_score <= 8'd0;
            r_hold       <= '0;
            r_prev_move  <= 1'b0;
        end else begin
            r_score <= w_score_next;
            r_hold  <= w_hold_next;
            if (i_frame_tick) begin
                r_prev_move <= i_move;
            end
            if (w_freeze_edge && (r_score > r_high_score)) begin
                r_high_score <= r_score;
            end
        end
    end

    assign o_score      = r_score;
    assign o_high_score = r_high_score;

    // ---------------- BCD converter FSM ----------------
    // Conversion is loaded on the same edge the score changes, so a new score
    // always restarts from LOAD and a stale result can never be published.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conv_state <= CV_IDLE;
        end else begin
            r_conv_state <= w_conv_next;
        end
    end

    always_comb begin
        w_conv_next = r_conv_state;
        if (w_score_chg) begin
            w_conv_next = CV_LOAD;
        end else begin
            case (r_conv_state)
                CV_LOAD:  w_conv_next = CV_SHIFT;
                CV_SHIFT: w_conv_next = (r_cnt == 3'd7) ? CV_IDLE : CV_SHIFT;
                default:  w_conv_next = CV_IDLE;
            endcase
        end
    end

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        w_bcd_adj  = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
        w_bcd_step = {w_bcd_adj[10:0], r_bin[7]};
        w_bin_step = {r_bin[6:0], 1'b0};
    end

    // Digit outputs only change on the final shift, so they never show a partial value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin       <= 8'd0;
            r_bcd       <= 12'd0;
            r_cnt       <= 3'd0;
            r_hundreds  <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_bcd_valid <= 1'b1;
        end else if (w_score_chg) begin
            r_bin <= w_score_next;
            r_bcd <= 12'd0;
            r_cnt <= 3'd0;
        end else begin
            case (r_conv_state)
                CV_LOAD: begin
                    r_bcd_valid <= 1'b0;
                    r_cnt       <= 3'd0;
                end
                CV_SHIFT: begin
                    r_bcd <= w_bcd_step;
                    r_bin <= w_bin_step;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_hundreds  <= w_bcd_step[11:8];
                        r_tens      <= w_bcd_step[7:4];
                        r_ones      <= w_bcd_step[3:0];
                        r_bcd_valid <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= 3'd0;
                end
            endcase
        end
    end

    assign o_hundreds  = r_hundreds;
    assign o_tens      = r_tens;
    assign o_ones      = r_ones;
    assign o_bcd_valid = r_bcd_valid;

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter SCORE_MAX, default 255, giving the saturation value of the score (at most 255).
REQ-002 SHALL have parameter HOLD_FRAMES, default 8, giving the number of frame ticks between auto-increments while move is held (at least 2).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-006 SHALL have port i_move, input, 1 bit: move-button level, already synchronised to i_clk.
REQ-007 SHALL have port i_game_over, input, 1 bit: collision level from the game logic.
REQ-008 SHALL have port i_restart, input, 1 bit: one-cycle restart pulse.
REQ-009 SHALL have port o_score, output, 8 bits: current score, feeding the score renderer.
REQ-010 SHALL have port o_high_score, output, 8 bits: best score since reset.
REQ-011 SHALL have ports o_hundreds, o_tens and o_ones, output, 4 bits each: BCD digits of o_score.
REQ-012 SHALL have port o_bcd_valid, output, 1 bit: high when the BCD digits match o_score.
REQ-013 SHALL have port o_frozen, output, 1 bit: high when the FSM is in the FROZEN state.

Function
REQ-014 SHALL implement a game FSM with two states, RUN and FROZEN.
REQ-015 SHALL move from RUN to FROZEN on any cycle where i_game_over=1 and i_restart=0.
REQ-016 SHALL move from FROZEN to RUN only on i_restart=1.
REQ-017 SHALL, on i_restart=1 in either state, in the same clock edge:
  - clear o_score to 0 and the hold counter to 0;
  - enter RUN;
  - take priority over i_game_over and i_frame_tick in that cycle.
REQ-018 SHALL evaluate i_move only on cycles with i_frame_tick=1 while in RUN with i_game_over=0; all other cycles leave score and hold counter unchanged.
REQ-019 SHALL register the frame-sampled move level (prev_move), updated on every i_frame_tick.
REQ-020 SHALL handle a press (i_move=1, prev_move=0) by incrementing o_score on that tick and setting the hold counter to 0.
REQ-021 SHALL handle a hold (i_move=1, prev_move=1) by incrementing the hold counter; when it reaches HOLD_FRAMES-1 it increments o_score and resets the counter to 0.
REQ-022 SHALL handle a release (i_move=0) by setting the hold counter to 0.
REQ-023 SHALL saturate o_score at SCORE_MAX: an increment at SCORE_MAX leaves it unchanged and starts no BCD conversion.
REQ-024 SHALL, on the RUN-to-FROZEN transition edge, update o_high_score to max(o_high_score, o_score); it is unchanged otherwise.
REQ-025 SHALL hold o_score constant while FROZEN.
REQ-026 SHALL derive the BCD digits with a sequential shift-add-3 (double-dabble) converter with states IDLE, LOAD and SHIFT; no divide or modulo operators are used.
REQ-027 SHALL, on any o_score change, drop o_bcd_valid to 0 the edge after o_score updates, then spend 1 LOAD cycle and 8 SHIFT cycles.
REQ-028 SHALL update the digit outputs and raise o_bcd_valid exactly 9 cycles after the o_score change, with all four outputs updating on the same edge.
REQ-029 SHALL hold the previous digit values on o_hundreds, o_tens and o_ones while a conversion is in progress, so the display never shows a partial result.
REQ-030 SHALL, if o_score changes mid-conversion (for example on restart), abort the conversion and start a new LOAD on the next cycle; only the final value is ever published.
REQ-031 SHALL never output a digit greater than 9; o_hundreds is at most 2.
REQ-032 SHALL drive o_frozen from the state register only (registered, no combinational path from inputs).

Reset
REQ-033 SHALL, on i_rst=1 at a clock edge, set:
  - o_score=0, o_high_score=0;
  - digits=0/0/0, o_bcd_valid=1;
  - state RUN, converter IDLE;
  - hold counter=0, prev_move=0.
REQ-034 SHALL give i_rst priority over all other inputs, including i_restart and conversions in progress.

Verification
REQ-035 Press and hold: i_move=1 for 17 frame ticks from score 0 with HOLD_FRAMES=8 -> o_score=3 (ticks 1, 9 and 17); digits 0/0/3, valid 9 cycles after the last increment.
REQ-036 Saturation: preload to 254 via presses, then 3 more presses -> o_score=255 and stays 255; digits 2/5/5; no conversion started after 255.
REQ-037 Game over: score 42, i_game_over=1 on the same cycle as a press tick -> FROZEN, o_score=42, o_high_score=42; later ticks with i_move=1 leave 42.
REQ-038 Restart and high score: from FROZEN with high 42, i_restart -> o_score=0, RUN; reach 10, game over -> o_high_score stays 42.
REQ-039 Restart mid-conversion: i_restart 3 cycles after a score change 99 to 100 -> o_bcd_valid stays 0 until digits 0/0/0, never shows 1/0/0.
REQ-040 Reset mid-operation: i_rst during FROZEN with an active conversion -> all REQ-033 values on the next edge.
